// File: rtl/action_selector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : action_selector_pkg
//  Description : Shared types and constants for the action selector: FSM
//                state encoding, action count and LFSR seed/tap constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package action_selector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DECIDE = 2'd2
    } state_t;

    localparam int          N_ACTIONS         = 16;
    localparam int          IDX_W             = 4;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
    // Taps 16,14,13,11 expressed as zero-based bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;

    // One Fibonacci step: shift left, feedback is the XOR of the tapped bits
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/action_selector_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances on
//                every clock out of reset. Supplies the exploration coin
//                and the random action index.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import action_selector_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    logic [15:0] r_lfsr;

    // Free-running shift register, reloaded with the seed on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign lfsr = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/action_selector.sv
`default_nettype none
// ============================================================================
//  Module      : action_selector
//  Description : Streams 16 signed Q-values, tracks the arg-max (lowest index
//                wins ties) and emits the selected action with a done pulse.
//                With EPSILON_GREEDY_EN defined, an LFSR-driven epsilon-greedy
//                choice may replace the greedy index with a random one.
//  Revision    : 1.0 - initial release
// ============================================================================
module action_selector
    import action_selector_pkg::*;
#(
    parameter int          Q_W       = 16,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  q_valid,
    input  logic signed [Q_W-1:0] q_in,
    input  logic [7:0]            epsilon,
    output logic                  busy,
    output logic [IDX_W-1:0]      at,
    output logic                  done,
    output logic                  explore
);

    localparam logic [IDX_W-1:0] c_last_beat = IDX_W'(N_ACTIONS - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_cnt;
    logic signed [Q_W-1:0]   r_best;
    logic [IDX_W-1:0]        r_best_idx;
    logic [IDX_W-1:0]        r_at;
    logic                    r_explore;
    logic                    r_done;
    logic                    w_beat;
    logic                    w_last_beat;
    logic [IDX_W-1:0]        w_sel_at;
    logic                    w_sel_explore;

    assign w_beat      = (r_state == ST_SCAN) && q_valid;
    assign w_last_beat = w_beat && (r_cnt == c_last_beat);

`ifdef EPSILON_GREEDY_EN
    logic [15:0] w_lfsr;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (w_lfsr)
    );

    // Explore when the low LFSR byte falls under the threshold
    assign w_sel_explore = (w_lfsr[7:0] < epsilon);
    assign w_sel_at      = w_sel_explore ? w_lfsr[11:8] : r_best_idx;
`else
    logic w_unused_epsilon;

    assign w_unused_epsilon = ^epsilon;
    assign w_sel_explore    = 1'b0;
    assign w_sel_at         = r_best_idx;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start only matters in IDLE, the scan ends on the 16th beat
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_SCAN;
            ST_SCAN:   if (w_last_beat) w_state_nxt = ST_DECIDE;
            ST_DECIDE: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Scan datapath: beat counter, running maximum and the registered decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_at       <= '0;
            r_explore  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt      <= '0;
                        r_best     <= '0;
                        r_best_idx <= '0;
                    end
                end
                ST_SCAN: begin
                    if (w_beat) begin
                        // Hold at the terminal count instead of wrapping
                        if (r_cnt != c_last_beat) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        // Strict compare keeps the earlier index on ties
                        if ((r_cnt == '0) || (q_in > r_best)) begin
                            r_best     <= q_in;
                            r_best_idx <= r_cnt;
                        end
                    end
                end
                ST_DECIDE: begin
                    r_at      <= w_sel_at;
                    r_explore <= w_sel_explore;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign at      = r_at;
    assign done    = r_done;
    assign explore = r_explore;

endmodule
`default_nettype wire

// File: tb/tb_action_selector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_action_selector
//  Description : Self-checking bench for action_selector. Directed cases plus
//                randomized selections compared against a behavioural model
//                (arg-max over an array and a stepped LFSR sequence).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_action_selector;

    localparam int          Q_W  = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  q_valid;
    logic signed [Q_W-1:0] q_in;
    logic [7:0]            epsilon;
    logic                  busy;
    logic [3:0]            at;
    logic                  done;
    logic                  explore;

    action_selector #(
        .Q_W       (Q_W),
        .LFSR_SEED (SEED)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .q_valid (q_valid),
        .q_in    (q_in),
        .epsilon (epsilon),
        .busy    (busy),
        .at      (at),
        .done    (done),
        .explore (explore)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference LFSR sequence: value during the current cycle and the one before
    logic [15:0] m_lfsr;
    logic [15:0] m_lfsr_prev;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr      <= SEED;
            m_lfsr_prev <= SEED;
        end else begin
            m_lfsr_prev <= m_lfsr;
            m_lfsr      <= lfsr_next(m_lfsr);
        end
    end

    // Count every done pulse, sampled just after the edge
    int done_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    logic signed [Q_W-1:0] qv [16];
    logic                  last_explore;

    function automatic int greedy_idx();
        int b;
        b = 0;
        for (int i = 1; i < 16; i++) begin
            if (qv[i] > qv[b]) b = i;
        end
        return b;
    endfunction

    // One selection starting at a negedge; gap_mode 0 none, 1 two idle cycles, 2 random
    task automatic do_scan(input int gap_mode, input bit issue_start, input string tag);
        int   g;
        int   exp_at;
        logic exp_exp;
        if (issue_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            g = (gap_mode == 1) ? 2 : ((gap_mode == 2) ? int'($urandom_range(0, 2)) : 0);
            repeat (g) begin
                q_valid = 1'b0;
                q_in    = Q_W'($urandom);
                @(negedge clk);
                if (gap_mode == 1) check({tag, "_busy_gap"}, busy, 1);
            end
            q_valid = 1'b1;
            q_in    = qv[i];
            @(negedge clk);
        end
        q_valid = 1'b0;
        q_in    = Q_W'($urandom);
        check({tag, "_busy_decide"}, busy, 1);
        check({tag, "_done_early"}, done, 0);
        @(negedge clk);
        exp_at  = greedy_idx();
        exp_exp = 1'b0;
`ifdef EPSILON_GREEDY_EN
        if (m_lfsr_prev[7:0] < epsilon) begin
            exp_exp = 1'b1;
            exp_at  = int'(m_lfsr_prev[11:8]);
        end
`endif
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_at"}, at, exp_at);
        check({tag, "_explore"}, explore, exp_exp);
        last_explore = explore;
    endtask

    int d0;
    int n_explore;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        q_valid = 1'b0;
        q_in    = '0;
        epsilon = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_at", at, 0);
        check("rst_explore", explore, 0);
        rst = 1'b0;
        @(negedge clk);

        // q_valid while idle must not start or disturb anything
        d0 = done_cnt;
        q_valid = 1'b1;
        q_in    = 16'sd32767;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);
        q_valid = 1'b0;

        // Greedy ascending
        for (int i = 0; i < 16; i++) qv[i] = Q_W'(10 * i);
        do_scan(0, 1'b1, "greedy");

        // Ties and signed values
        for (int i = 0; i < 16; i++) qv[i] = -16'sd5;
        qv[3] = 16'sd7;
        qv[9] = 16'sd7;
        do_scan(0, 1'b1, "tie");
        for (int i = 0; i < 16; i++) qv[i] = -16'sd32768;
        do_scan(0, 1'b1, "allmin");

        // Stalled stream, max at 6, single done and held result
        for (int i = 0; i < 16; i++) qv[i] = Q_W'(i * 3 - 40);
        qv[6] = 16'sd1000;
        d0 = done_cnt;
        do_scan(1, 1'b1, "stall");
        repeat (3) @(negedge clk);
        check("stall_one_done", done_cnt - d0, 1);
        check("stall_at_hold", at, 6);

        // Reset after 8 beats aborts the scan
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            q_valid = 1'b1;
            q_in    = 16'sd20000;
            @(negedge clk);
        end
        q_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        for (int i = 0; i < 16; i++) qv[i] = Q_W'(-i);
        qv[12] = 16'sd500;
        do_scan(0, 1'b1, "restart");

        // Back-to-back: start on the done cycle, stray q_valid ignored
        for (int i = 0; i < 16; i++) qv[i] = Q_W'(i);
        do_scan(0, 1'b1, "b2b_first");
        start   = 1'b1;
        q_valid = 1'b1;
        q_in    = 16'sd32767;
        @(negedge clk);
        start   = 1'b0;
        q_valid = 1'b0;
        check("b2b_busy", busy, 1);
        for (int i = 0; i < 16; i++) qv[i] = Q_W'(100 - i);
        qv[9] = 16'sd300;
        do_scan(0, 1'b0, "b2b_second");

        // High-epsilon batch of random selections
        epsilon   = 8'd255;
        n_explore = 0;
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < 16; i++) qv[i] = Q_W'($urandom);
            do_scan(0, 1'b1, "eps255");
            if (last_explore === 1'b1) n_explore++;
        end
`ifdef EPSILON_GREEDY_EN
        check("explore_ratio", (n_explore >= 990) ? 1 : 0, 1);
`else
        check("explore_never", n_explore, 0);
`endif

        // Random epsilon, random gaps, narrow value range to provoke ties
        for (int k = 0; k < 100; k++) begin
            epsilon = 8'($urandom);
            for (int i = 0; i < 16; i++) qv[i] = Q_W'($urandom_range(0, 7)) - 16'sd4;
            do_scan(2, 1'b1, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/action_selector.md
ACTION_SELECTOR -- requirements
Module: action_selector

Interface
REQ-001 Parameter Q_W, default 16: width of each signed Q-value.
REQ-002 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; shall be nonzero.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a 16-action selection.
REQ-006 q_valid  input  1  q_in carries a valid Q-value this cycle.
REQ-007 q_in  input  Q_W  signed Q-value; beats arrive in action order 0..15.
REQ-008 epsilon  input  8  exploration threshold (0 = pure greedy, 255 ≈ 99.6% explore).
REQ-009 busy  output  1  high from the cycle after start is accepted until done.
REQ-010 at  output  4  selected action index; feeds the 4-to-16 one-hot enable decoder.
REQ-011 done  output  1  one-cycle pulse; at is valid and held from this cycle onward.
REQ-012 explore  output  1  at was chosen randomly (valid with done, held with at).

Function
REQ-013 FSM states IDLE, SCAN, DECIDE; IDLE -> SCAN on start; SCAN -> DECIDE after the 16th accepted beat; DECIDE -> IDLE unconditionally.
REQ-014 In IDLE, q_valid beats shall be ignored; in SCAN/DECIDE, start shall be ignored.
REQ-015 On entering SCAN, the 4-bit beat counter, best value and best index shall clear; the first beat loads best unconditionally.
REQ-016 Each later beat shall replace best only if q_in > best (signed compare); ties keep the lower index.
REQ-017 Beats with q_valid low in SCAN shall stall the scan with no state change; no timeout.
REQ-018 The counter shall use the beat-15 terminal value to leave SCAN, with no wrap-around into a 17th beat.
REQ-019 In DECIDE, at/explore shall register and done shall pulse on the next edge, i.e. one cycle after the 16th beat.
REQ-020 busy shall be high in SCAN and DECIDE and low in IDLE, including the done cycle.
REQ-021 A start in the same cycle done pulses (state IDLE) shall be accepted.
REQ-022 at and explore shall hold their value until the next done.

Reset
REQ-023 rst shall force IDLE, busy=0, done=0, at=4'd0, explore=0, counter=0, best=0, and LFSR=LFSR_SEED.
REQ-024 rst asserted mid-SCAN shall abort the selection; no done shall be issued for it.

Configuration
REQ-025 With EPSILON_GREEDY_EN defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) shall advance every cycle out of reset.
- In DECIDE, if lfsr[7:0] < epsilon: at = lfsr[11:8] and explore = 1.
- Otherwise: at = best index and explore = 0.
REQ-026 Without EPSILON_GREEDY_EN, the LFSR shall be absent, epsilon unused, explore tied 0, and at always the greedy index.

Structure
REQ-027 A shared package shall hold the FSM state typedef, N_ACTIONS=16, and the default LFSR seed/taps constants.
REQ-028 The LFSR shall be a sub-module named lfsr16, instantiated only under EPSILON_GREEDY_EN.

Verification
REQ-029 Greedy: epsilon=0, Q = 0..15 ascending (values 10*i) -> done 1 cycle after beat 15, at=15, explore=0.
REQ-030 Tie/sign: Q all -5 except Q[3]=Q[9]=+7 -> at=3; all Q=-32768 -> at=0.
REQ-031 Stall: q_valid gapped (1 of 3 cycles), max at index 6 -> at=6, busy high throughout, single done pulse.
REQ-032 Reset mid-scan after 8 beats, then a fresh start with max at 12 -> no done before restart; at=12.
REQ-033 Explore (macro on): epsilon=255, 1000 selections -> explore=1 on ≥99% of them, at matches lfsr[11:8] model; macro off -> explore always 0.
REQ-034 Back-to-back: start asserted on the done cycle -> new scan accepted, busy high next cycle, q_valid in IDLE ignored.
